// File: rtl/imem_arbiter.sv
// imem_arbiter: two-core round-robin arbiter in front of a shared single-port
// instruction memory with combinational read. A grant in cycle T returns the
// memory word to the granted core as a registered response in cycle T+1,
// together with a misalignment flag. Per-core saturating grant counters are
// kept for observability.
module imem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [CNT_W-1:0]  gcnt0,
  output logic [CNT_W-1:0]  gcnt1
);

  // Index of the core served by the most recent grant; the other core wins
  // the next conflict. Reset to 1 so that core 0 wins the first conflict.
  logic last_grant;

  logic misaligned0;
  logic misaligned1;

  assign misaligned0 = (addr0[1:0] != 2'b00);
  assign misaligned1 = (addr1[1:0] != 2'b00);

  // Grant decision: at most one core per cycle, round-robin on conflict,
  // suppressed entirely during reset or hold.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !hold) begin
      if (req0 && (!req1 || last_grant)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Memory address mux: core 1 only when it holds the grant, core 0 otherwise
  // (including idle cycles).
  always_comb begin
    mem_addr = gnt1 ? addr1 : addr0;
  end

  // Arbitration history: remembers the last served core; idle cycles keep it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end
  end

  // Core 0 response path: one-cycle registered valid, data and error flag.
  always_ff @(posedge clk) begin
    // NOTE: the read-data registers are cleared on reset as well, so the
    // data outputs come out of reset at a defined zero instead of stale values.
    if (reset) begin
      rvalid0 <= 1'b0;
      rdata0  <= '0;
      err0    <= 1'b0;
    end else begin
      rvalid0 <= gnt0;
      err0    <= gnt0 && misaligned0;
      if (gnt0) begin
        rdata0 <= mem_rd;
      end
    end
  end

  // Core 1 response path: mirror of core 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid1 <= 1'b0;
      rdata1  <= '0;
      err1    <= 1'b0;
    end else begin
      rvalid1 <= gnt1;
      err1    <= gnt1 && misaligned1;
      if (gnt1) begin
        rdata1 <= mem_rd;
      end
    end
  end

  // Grant counters: count granted cycles per core, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else begin
      if (gnt0 && (gcnt0 != {CNT_W{1'b1}})) begin
        gcnt0 <= gcnt0 + CNT_W'(1);
      end
      if (gnt1 && (gcnt1 != {CNT_W{1'b1}})) begin
        gcnt1 <= gcnt1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed-vector bench for imem_arbiter. The stimulus
// process checks grants and the memory address each cycle and pushes the
// expected response of every grant into a per-core scoreboard queue; a
// separate monitor pops and compares whenever a response is due or presented.
module tb_imem_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              hold;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              err0, err1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd;
  logic [CNT_W-1:0]  gcnt0, gcnt1;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sb[2][$];

  imem_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .hold    (hold),
    .req0    (req0),
    .req1    (req1),
    .addr0   (addr0),
    .addr1   (addr1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1),
    .rdata0  (rdata0),
    .rdata1  (rdata1),
    .err0    (err0),
    .err1    (err1),
    .mem_addr(mem_addr),
    .mem_rd  (mem_rd),
    .gcnt0   (gcnt0),
    .gcnt1   (gcnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared memory: word n holds 0xAAAA0000 + n, low address bits ignored.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hAAAA, a[17:2]};
  endfunction

  assign mem_rd = mem_word(mem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor step for one core, run on the falling edge.
  task automatic mon_core(input int idx, input logic rv, input logic [31:0] rd, input logic er);
    exp_t e;
    logic exp_v;
    while (sb[idx].size() > 0 && sb[idx][0].due < cyc) begin
      note_fail($sformatf("core%0d rvalid missing for due cycle %0d", idx, sb[idx][0].due));
      void'(sb[idx].pop_front());
    end
    exp_v = (sb[idx].size() > 0) && (sb[idx][0].due == cyc);
    if (rv === 1'b1 || exp_v) begin
      check($sformatf("core%0d rvalid", idx), 64'(rv), 64'(exp_v));
      if (exp_v) begin
        e = sb[idx].pop_front();
        check($sformatf("core%0d rdata", idx), 64'(rd), 64'(e.data));
        check($sformatf("core%0d err", idx), 64'(er), 64'(e.err));
      end
    end
  endtask

  // One cycle of stimulus with the expected grants for that cycle.
  task automatic drive(input logic r, input logic q0, input logic q1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic h, input logic eg0, input logic eg1,
                       input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; req0 = q0; req1 = q1; addr0 = a0; addr1 = a1; hold = h;
    #1;
    check({tag, " gnt0"}, 64'(gnt0), 64'(eg0));
    check({tag, " gnt1"}, 64'(gnt1), 64'(eg1));
    check({tag, " mem_addr"}, 64'(mem_addr), 64'(eg1 ? a1 : a0));
    if (eg0) begin
      e.due = cyc + 1; e.data = mem_word(a0); e.err = (a0[1:0] != 2'b00);
      sb[0].push_back(e);
    end
    if (eg1) begin
      e.due = cyc + 1; e.data = mem_word(a1); e.err = (a1[1:0] != 2'b00);
      sb[1].push_back(e);
    end
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;

    fork
      forever begin
        @(negedge clk);
        mon_core(0, rvalid0, rdata0, err0);
        mon_core(1, rvalid1, rdata1, err1);
      end
    join_none

    // Reset with a pending request: grants forced low, state cleared.
    drive(1'b1, 1'b1, 1'b1, 32'h8, 32'h4, 1'b0, 1'b0, 1'b0, "rst0");
    drive(1'b1, 1'b1, 1'b1, 32'h8, 32'h4, 1'b0, 1'b0, 1'b0, "rst1");
    check("rst rvalid0", 64'(rvalid0), 64'd0);
    check("rst rdata0", 64'(rdata0), 64'd0);
    check("rst err1", 64'(err1), 64'd0);
    check("rst gcnt0", 64'(gcnt0), 64'd0);
    check("rst gcnt1", 64'(gcnt1), 64'd0);

    // Single core fetch of word 2.
    drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 1'b0, "single");
    idle("single_resp");
    check("single rdata0", 64'(rdata0), 64'hAAAA0002);
    check("single gcnt0", 64'(gcnt0), 64'd1);

    // Misaligned core 1 fetch: word 1 returned with err1.
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h6, 1'b0, 1'b0, 1'b1, "misal");
    idle("misal_resp");
    check("misal rdata1", 64'(rdata1), 64'hAAAA0001);
    check("misal gcnt1", 64'(gcnt1), 64'd1);

    // Contention from reset release: 0,1,0,1.
    drive(1'b1, 1'b1, 1'b1, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, "cont_rst");
    drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h4, 1'b0, 1'b1, 1'b0, "cont1");
    drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h4, 1'b0, 1'b0, 1'b1, "cont2");
    drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h4, 1'b0, 1'b1, 1'b0, "cont3");
    drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h4, 1'b0, 1'b0, 1'b1, "cont4");
    idle("cont_end");
    check("cont gcnt0", 64'(gcnt0), 64'd2);
    check("cont gcnt1", 64'(gcnt1), 64'd2);

    // Hold: core 0 served just before hold, so core 1 resumes afterwards.
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h14, 1'b0, 1'b1, 1'b0, "pre_hold");
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h14, 1'b1, 1'b0, 1'b0, "hold1");
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h14, 1'b1, 1'b0, 1'b0, "hold2");
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h14, 1'b1, 1'b0, 1'b0, "hold3");
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h14, 1'b0, 1'b0, 1'b1, "post_hold1");
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h14, 1'b0, 1'b1, 1'b0, "post_hold2");
    idle("hold_end");
    check("hold gcnt0", 64'(gcnt0), 64'd4);
    check("hold gcnt1", 64'(gcnt1), 64'd3);

    // Reset right after a core 1 grant: counters cleared, core 0 wins next.
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h24, 1'b0, 1'b0, 1'b1, "mid_gnt");
    drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h24, 1'b0, 1'b0, 1'b0, "mid_rst");
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h24, 1'b0, 1'b1, 1'b0, "mid_after");
    check("mid gcnt1", 64'(gcnt1), 64'd0);
    check("mid rvalid1", 64'(rvalid1), 64'd0);
    idle("mid_end");
    check("mid gcnt0", 64'(gcnt0), 64'd1);

    // Saturation: 20 back-to-back uncontended core 0 grants.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "sat_rst");
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0, 1'b1, 1'b0, $sformatf("sat%0d", i));
    end
    idle("sat_resp");
    idle("sat_end");
    check("sat gcnt0", 64'(gcnt0), 64'd15);
    check("sat rdata0 held", 64'(rdata0), 64'hAAAA0013);
    check("sat rvalid0 low", 64'(rvalid0), 64'd0);

    idle("drain0");
    idle("drain1");
    check("sb0 drained", 64'(sb[0].size()), 64'd0);
    check("sb1 drained", 64'(sb[1].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
